// File: rtl/instr_mem_loader_pkg.sv
// Shared pipeline definitions for the instruction-memory loader:
// loader FSM states and the default program terminator word.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StError
    } loader_state_e;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Collects received bytes little-endian into a word and flags the byte that completes it.
// o_word is the word including the current byte, so the caller can register it on completion.
module instr_mem_loader_byte_assembler #(
    parameter int unsigned NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_data,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_complete
);

    localparam int unsigned NB_BYTES = NB_DATA / 8;
    localparam int unsigned CNT_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_BYTES - 1);

    logic [CNT_W-1:0]   cnt_q;
    logic [NB_DATA-1:0] shift_q;

    // New bytes enter at the top, so after NB_BYTES shifts the first byte sits in [7:0].
    assign o_word     = {i_data, shift_q[NB_DATA-1:8]};
    assign o_complete = i_valid && (cnt_q == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (i_valid) begin
            shift_q <= o_word;
            cnt_q   <= o_complete ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program received byte-wise into instruction memory, word by word, until
// HALT_WORD is written or the memory is full; holds the PC while a load is in progress.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned        NB_DATA   = 32,
    parameter int unsigned        NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0] o_imem_data,
    output logic               o_pc_write,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};
    localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(4);

    loader_state_e state_q, state_d;

    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [NB_DATA-1:0] wr_data_q, wr_data_d;
    logic               we_q, we_d;
    logic               pc_write_q, pc_write_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               asm_clear;
    logic               asm_valid;
    logic [NB_DATA-1:0] asm_word;
    logic               asm_complete;

    instr_mem_loader_byte_assembler #(
        .NB_DATA (NB_DATA)
    ) u_byte_assembler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (asm_clear),
        .i_valid    (asm_valid),
        .i_data     (i_rx_data),
        .o_word     (asm_word),
        .o_complete (asm_complete)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        we_d      = 1'b0;
        done_d    = done_q;
        error_d   = error_q;
        asm_clear = 1'b0;
        asm_valid = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (i_start) begin
                    state_d   = StRecv;
                    addr_d    = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    asm_clear = 1'b1;
                end
            end
            StRecv: begin
                asm_valid = i_rx_valid;
                if (asm_complete) begin
                    state_d   = StWrite;
                    we_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = asm_word;
                end
            end
            StWrite: begin
                // wr_data_q still holds the word being written this cycle.
                if (wr_data_q == HALT_WORD) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else begin
                    state_d   = StRecv;
                    addr_d    = addr_q + WORD_STEP;
                    asm_valid = i_rx_valid;
                end
            end
            default: state_d = StIdle;
        endcase

        pc_write_d = (state_d == StIdle) || (state_d == StDone);
        busy_d     = (state_d == StRecv) || (state_d == StWrite);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            we_q       <= 1'b0;
            pc_write_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            we_q       <= we_d;
            pc_write_q <= pc_write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign o_imem_we   = we_q;
    assign o_imem_addr = wr_addr_q;
    assign o_imem_data = wr_data_q;
    assign o_pc_write  = pc_write_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default instance plus a 16-byte-memory instance
// driven by the same stimulus, checked against hand-computed values.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        we, pc_write, busy, done, error;
    logic [9:0]  addr;
    logic [31:0] data;

    logic        s_we, s_pc_write, s_busy, s_done, s_error;
    logic [3:0]  s_addr;
    logic [31:0] s_data;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int s_wr_cnt = 0;
    int base;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    instr_mem_loader dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_imem_we   (we),
        .o_imem_addr (addr),
        .o_imem_data (data),
        .o_pc_write  (pc_write),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error)
    );

    instr_mem_loader #(
        .NB_ADDR (4)
    ) dut_small (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_imem_we   (s_we),
        .o_imem_addr (s_addr),
        .o_imem_data (s_data),
        .o_pc_write  (s_pc_write),
        .o_busy      (s_busy),
        .o_done      (s_done),
        .o_error     (s_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            wr_cnt++;
            log_addr.push_back({22'b0, addr});
            log_data.push_back(data);
        end
        if (s_we) s_wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(we), 64'd0);
        check({tag, "_addr"}, 64'(addr), 64'd0);
        check({tag, "_data"}, 64'(data), 64'd0);
        check({tag, "_pc"}, 64'(pc_write), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("rst");
        check("rst_s_error", 64'(s_error), 64'd0);

        // First word, little-endian assembly
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_pc", 64'(pc_write), 64'd0);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h08); send_byte(8'h20);
        check("w0_we", 64'(we), 64'd1);
        check("w0_addr", 64'(addr), 64'd0);
        check("w0_data", 64'(data), 64'h2008_0013);
        tick();
        check("w0_we_drop", 64'(we), 64'd0);
        check("w0_recv_busy", 64'(busy), 64'd1);
        check("w0_recv_pc", 64'(pc_write), 64'd0);
        check("w0_hold_addr", 64'(addr), 64'd0);
        check("w0_hold_data", 64'(data), 64'h2008_0013);
        check("w0_cnt", 64'(wr_cnt), 64'd1);

        // Second word, then halt word
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        check("halt_we", 64'(we), 64'd1);
        check("halt_addr", 64'(addr), 64'd8);
        check("halt_data", 64'(data), 64'hFFFF_FFFF);
        tick();
        check("done_done", 64'(done), 64'd1);
        check("done_pc", 64'(pc_write), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_error", 64'(error), 64'd0);
        check("done_cnt", 64'(wr_cnt), 64'd3);
        check("w1_addr", 64'(log_addr[1]), 64'd4);
        check("w1_data", 64'(log_data[1]), 64'h1122_3344);
        check("w2_addr", 64'(log_addr[2]), 64'd8);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        check("done_ignore_cnt", 64'(wr_cnt), 64'd3);
        check("done_hold", 64'(done), 64'd1);

        // Overflow on the 16-byte instance
        do_reset();
        base = s_wr_cnt;
        pulse_start();
        for (int w = 1; w <= 4; w++) begin
            send_byte(8'(w)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        check("ovf_we", 64'(s_we), 64'd1);
        check("ovf_addr", 64'(s_addr), 64'd12);
        check("ovf_data", 64'(s_data), 64'h0000_0004);
        tick();
        check("ovf_error", 64'(s_error), 64'd1);
        check("ovf_pc", 64'(s_pc_write), 64'd0);
        check("ovf_busy", 64'(s_busy), 64'd0);
        check("ovf_done", 64'(s_done), 64'd0);
        check("ovf_cnt", 64'(s_wr_cnt - base), 64'd4);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        tick();
        check("ovf_ignore_cnt", 64'(s_wr_cnt - base), 64'd4);
        check("ovf_hold", 64'(s_error), 64'd1);

        // Reset in the middle of a word
        do_reset();
        check("rst2_s_error", 64'(s_error), 64'd0);
        pulse_start();
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        tick();
        send_byte(8'hAA); send_byte(8'hBB);
        base = wr_cnt;
        do_reset();
        tick();
        check_reset_outputs("midrst");
        check("midrst_cnt", 64'(wr_cnt - base), 64'd0);
        pulse_start();
        send_byte(8'hCC); send_byte(8'hDD); send_byte(8'hEE); send_byte(8'h10);
        check("reload_addr", 64'(addr), 64'd0);
        check("reload_data", 64'(data), 64'h10EE_DDCC);
        tick();
        check("reload_cnt", 64'(wr_cnt - base), 64'd1);

        // Start mid-RECV ignored; byte during WRITE starts the next word
        send_byte(8'h5A);
        pulse_start();
        send_byte(8'h6B); send_byte(8'h7C);
        check("midstart_busy", 64'(busy), 64'd1);
        send_byte(8'h8D);
        check("midstart_addr", 64'(addr), 64'd4);
        check("midstart_data", 64'(data), 64'h8D7C_6B5A);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hE1;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'hE2); send_byte(8'hE3); send_byte(8'hE4);
        check("wrbyte_we", 64'(we), 64'd1);
        check("wrbyte_addr", 64'(addr), 64'd8);
        check("wrbyte_data", 64'(data), 64'hE4E3_E2E1);
        tick();

        // Bytes in IDLE ignored; reset beats simultaneous start
        do_reset();
        base = wr_cnt;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        check("idle_rx_cnt", 64'(wr_cnt - base), 64'd0);
        check("idle_rx_busy", 64'(busy), 64'd0);
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_pc", 64'(pc_write), 64'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick();
        check("rst_start_cnt", 64'(wr_cnt - base), 64'd0);
        check("rst_start_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
